// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 keypad scanner.
//               - state_t        : scanner FSM states
//               - c_key_map      : hex code per key, indexed {row, col}
//               - lowest_low_row : index of the lowest-numbered active row
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Element [{row, col}] is the hex code printed on that key.
    // Leftmost entry is index 15 (row 3, col 3).
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: * 0 # D  (* = E, # = F)
    localparam logic [15:0][3:0] c_key_map = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Rows are active-low; the lowest index among the low rows wins.
    // Returns 3 when no row is low, callers only use it when one is.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage : keypad_pkg

`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
// ============================================================================
// Module      : sync2
// Description : Parameterised-width two-flop synchronizer. Resets to all
//               ones so idle (pulled-up) active-low inputs read as inactive.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input bus
//               q     - synchronized output bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync2

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with debounce. Drives one column
//               low at a time, samples the synchronized rows once per column
//               slot, debounces press and release, and reports the hex code.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               row[3:0]  - keypad rows, active-low, asynchronous
//               col[3:0]  - column drive, active-low one-hot
//               key[3:0]  - code of the last accepted key (held)
//               key_valid - one-cycle pulse on accepted press
//               key_down  - high from press acceptance to release acceptance
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam int c_slot_w = $clog2(SCAN_DIV);
    localparam int c_cnt_w  = $clog2(DEBOUNCE + 1);

    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_max   = c_cnt_w'(DEBOUNCE);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);

    // ------------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------------
    logic [3:0] w_row_sync;

    sync2 #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row),
        .q     (w_row_sync)
    );

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t              r_state,      w_state_nxt;
    logic [c_slot_w-1:0] r_slot;
    logic [1:0]          r_col_idx,    w_col_idx_nxt;
    logic [1:0]          r_cand,       w_cand_nxt;
    logic [c_cnt_w-1:0]  r_cnt,        w_cnt_nxt;
    logic [3:0]          r_key,        w_key_nxt;
    logic                r_key_valid,  w_key_valid_nxt;
    logic                r_key_down,   w_key_down_nxt;
    logic [3:0]          r_col;

    logic                w_sample;
    logic                w_rows_idle;
    logic [1:0]          w_low_row;
    logic [c_cnt_w-1:0]  w_cnt_inc;

    assign w_sample    = (r_slot == c_slot_last);
    assign w_rows_idle = &w_row_sync;
    assign w_low_row   = lowest_low_row(w_row_sync);
    // Saturating increment: the count never wraps past DEBOUNCE.
    assign w_cnt_inc   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    // ------------------------------------------------------------------------
    // Slot counter. Release is only ever accepted on a sample, where the
    // counter wraps to 0 anyway, so the restart on release needs no extra
    // control.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (w_sample) begin
            r_slot <= '0;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_col_idx   <= 2'd0;
            r_col       <= 4'b1110;
            r_cand      <= 2'd0;
            r_cnt       <= '0;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_idx_nxt;
            // Column drive is registered so the pad sees a clean one-hot-low
            // transition rather than a decoder output.
            r_col       <= ~(4'b0001 << w_col_idx_nxt);
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key       <= w_key_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_down  <= w_key_down_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic. All decisions happen on sample cycles only, so
    // every register (including the column) changes only after a sample.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_col_idx_nxt   = r_col_idx;
        w_cand_nxt      = r_cand;
        w_cnt_nxt       = r_cnt;
        w_key_nxt       = r_key;
        w_key_valid_nxt = 1'b0;
        w_key_down_nxt  = r_key_down;

        case (r_state)
            ST_SCAN: begin
                if (w_sample) begin
                    if (!w_rows_idle) begin
                        // Lock the column on the first closure seen.
                        w_cand_nxt = w_low_row;
                        if (DEBOUNCE == 1) begin
                            w_key_nxt       = c_key_map[{w_low_row, r_col_idx}];
                            w_key_valid_nxt = 1'b1;
                            w_key_down_nxt  = 1'b1;
                            w_cnt_nxt       = '0;
                            w_state_nxt     = ST_HELD;
                        end else begin
                            w_cnt_nxt   = c_cnt_one;
                            w_state_nxt = ST_CONFIRM;
                        end
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
            end

            ST_CONFIRM: begin
                if (w_sample) begin
                    if (!w_row_sync[r_cand]) begin
                        if (w_cnt_inc == c_cnt_max) begin
                            w_key_nxt       = c_key_map[{r_cand, r_col_idx}];
                            w_key_valid_nxt = 1'b1;
                            w_key_down_nxt  = 1'b1;
                            // Count is reused for release debounce in HELD.
                            w_cnt_nxt       = '0;
                            w_state_nxt     = ST_HELD;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        // Bounce: abandon silently and move on.
                        w_cnt_nxt     = '0;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                        w_state_nxt   = ST_SCAN;
                    end
                end
            end

            ST_HELD: begin
                if (w_sample) begin
                    if (w_rows_idle) begin
                        if (w_cnt_inc == c_cnt_max) begin
                            w_key_down_nxt = 1'b0;
                            w_cnt_nxt      = '0;
                            w_col_idx_nxt  = 2'd0;
                            w_state_nxt    = ST_SCAN;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        // Any closure in the locked column, including a
                        // second key, restarts the release count.
                        w_cnt_nxt = '0;
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_SCAN;
                w_cnt_nxt     = '0;
                w_col_idx_nxt = 2'd0;
            end
        endcase
    end

    assign col       = r_col;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;

endmodule : keypad_scanner

`default_nettype wire
